// File: rtl/npu_inst_pkg.sv
// Shared definitions for the NPU instruction fetch path.
package npu_inst_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 128;
    localparam int OP_HI  = 127;
    localparam int OP_LO  = 124;

    localparam logic [3:0] HALT_OP = 4'h8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN
    } fetch_state_e;

    function automatic logic is_halt(input logic [DATA_W-1:0] inst);
        return inst[OP_HI:OP_LO] == HALT_OP;
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Pointer-based synchronous FIFO with occupancy count and flush.
module inst_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = count_q == '0;
    assign full    = count_q == (PTR_W+1)'(DEPTH);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + (PTR_W+1)'(do_push)
                              - (PTR_W+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction SRAM sequencer: host load port while idle, prefetch
// into a small FIFO and hand instructions to the decoder until HALT.
module inst_fetch_ctrl
    import npu_inst_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_d,
    output logic              sram_we,
    input  logic [DATA_W-1:0] sram_q,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W = DATA_W + ADDR_W;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_pend_q, rd_pend_d;
    logic              halt_seen_q, halt_seen_d;

    logic              is_idle, issue, push, pop, flush;
    logic              fifo_empty, fifo_full;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    credit;
    logic [ENT_W-1:0]  head;

    assign is_idle  = state_q == S_IDLE;
    assign busy     = !is_idle;
    assign host_ack = is_idle && host_we;
    assign sram_we  = is_idle && host_we;
    assign sram_d   = is_idle ? host_wdata : '0;

    // Outstanding read counts against FIFO space so a push never overflows.
    assign credit = {1'b0, fifo_count} + (CNT_W+1)'(rd_pend_q);
    assign issue  = (state_q == S_FETCH) && !halt_seen_q
                 && (credit < (CNT_W+1)'(FIFO_DEPTH));

    assign sram_addr = is_idle ? host_addr : (issue ? pc_q : addr_q);

    assign push = (state_q == S_FETCH) && rd_pend_q && !halt_seen_q
               && (!fifo_full || pop);

    assign inst_valid = !fifo_empty;
    assign pop        = inst_valid && inst_ready;
    assign inst_data  = head[DATA_W-1:0];
    assign inst_pc    = head[ENT_W-1 -: ADDR_W];

    assign done  = (state_q == S_DRAIN) && pop && is_halt(inst_data)
                && !abort;
    assign flush = !is_idle && (abort || done);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        tag_d       = tag_q;
        rd_pend_d   = rd_pend_q;
        halt_seen_d = halt_seen_q;
        addr_d      = sram_addr;
        unique case (state_q)
            S_IDLE: begin
                if (start && !host_we) begin
                    pc_d    = start_pc;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                rd_pend_d = issue;
                tag_d     = pc_q;
                if (issue) pc_d = pc_q + ADDR_W'(1);
                if (push && is_halt(sram_q)) begin
                    halt_seen_d = 1'b1;
                    state_d     = S_DRAIN;
                end
            end
            S_DRAIN: begin
                rd_pend_d = 1'b0;
                if (done) begin
                    state_d     = S_IDLE;
                    halt_seen_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort && !is_idle) begin
            state_d     = S_IDLE;
            rd_pend_d   = 1'b0;
            halt_seen_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            tag_q       <= '0;
            addr_q      <= '0;
            rd_pend_q   <= 1'b0;
            halt_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            tag_q       <= tag_d;
            addr_q      <= addr_d;
            rd_pend_q   <= rd_pend_d;
            halt_seen_q <= halt_seen_d;
        end
    end

    inst_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata ({tag_q, sram_q}),
        .rdata (head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl with an SRAM and program model.
module tb_inst_fetch_ctrl;
    import npu_inst_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] start_pc;
    logic              abort;
    logic              busy, done;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ack;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_d;
    logic              sram_we;
    logic [DATA_W-1:0] sram_q;
    logic              inst_valid, inst_ready;
    logic [DATA_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;

    logic [DATA_W-1:0] sram    [512];
    logic [DATA_W-1:0] ref_mem [512];
    int                exp_pc[$];
    int                got_pc[$];
    int                checks   = 0;
    int                failures = 0;
    int                mon_e;
    logic              prev_stall = 1'b0;
    logic              prev_abort = 1'b0;
    logic [ADDR_W-1:0] prev_pc;
    logic [DATA_W-1:0] prev_data;
    logic [DATA_W-1:0] junk;

    always #5 clk = ~clk;

    inst_fetch_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_pc   (start_pc),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .sram_addr  (sram_addr),
        .sram_d     (sram_d),
        .sram_we    (sram_we),
        .sram_q     (sram_q),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_data  (inst_data),
        .inst_pc    (inst_pc)
    );

    // Synchronous-read SRAM, one cycle of read latency.
    always @(posedge clk) begin
        if (sram_we) sram[sram_addr] <= sram_d;
        sram_q <= sram[sram_addr];
    end

    function automatic void chk(input string nm,
                                input logic [DATA_W-1:0] act,
                                input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endfunction

    // Every accepted instruction must be the next one of the program.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
            prev_abort <= 1'b0;
        end else begin
            if (prev_stall && !prev_abort) begin
                chk("stall_valid", DATA_W'(inst_valid), DATA_W'(1));
                chk("stall_pc", DATA_W'(inst_pc), DATA_W'(prev_pc));
                chk("stall_data", inst_data, prev_data);
            end
            if (inst_valid && inst_ready) begin
                chk("pop_expected", DATA_W'(exp_pc.size() > 0), DATA_W'(1));
                if (exp_pc.size() > 0) begin
                    mon_e = exp_pc.pop_front();
                    got_pc.push_back(int'(inst_pc));
                    chk("pop_pc", DATA_W'(inst_pc), DATA_W'(mon_e));
                    chk("pop_data", inst_data, ref_mem[mon_e]);
                    chk("pop_done", DATA_W'(done),
                        DATA_W'(ref_mem[mon_e][127:124] == 4'h8 && !abort));
                end
            end else begin
                chk("done_quiet", DATA_W'(done), DATA_W'(0));
            end
            prev_stall <= inst_valid && !inst_ready;
            prev_abort <= abort;
            prev_pc    <= inst_pc;
            prev_data  <= inst_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input int a, input logic [DATA_W-1:0] d);
        host_we    = 1'b1;
        host_addr  = ADDR_W'(a);
        host_wdata = d;
        ref_mem[a] = d;
        @(negedge clk);
        chk("host_ack", DATA_W'(host_ack), DATA_W'(1));
        chk("host_we_out", DATA_W'(sram_we), DATA_W'(1));
        tick();
        host_we = 1'b0;
    endtask

    // Expected program: consecutive wrapping addresses up to the HALT word.
    task automatic arm(input int pc);
        int p;
        p = pc;
        exp_pc.delete();
        got_pc.delete();
        for (int i = 0; i < 600; i++) begin
            exp_pc.push_back(p);
            if (ref_mem[p][127:124] == 4'h8) break;
            p = (p + 1) % 512;
        end
        start    = 1'b1;
        start_pc = ADDR_W'(pc);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_idle"}, DATA_W'(busy), DATA_W'(0));
        chk({nm, "_delivered"}, DATA_W'(exp_pc.size()), DATA_W'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 512; i++) ref_mem[i] = '0;
        rst_n      = 1'b0;
        start      = 1'b0;
        start_pc   = '0;
        abort      = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        inst_ready = 1'b0;
        #12;
        chk("rst_busy", DATA_W'(busy), DATA_W'(0));
        chk("rst_done", DATA_W'(done), DATA_W'(0));
        chk("rst_valid", DATA_W'(inst_valid), DATA_W'(0));
        chk("rst_ack", DATA_W'(host_ack), DATA_W'(0));
        chk("rst_we", DATA_W'(sram_we), DATA_W'(0));
        chk("rst_addr", DATA_W'(sram_addr), DATA_W'(0));
        chk("rst_d", sram_d, DATA_W'(0));
        rst_n = 1'b1;
        tick();

        // Two-word program, latency and done timing.
        host_write(0, {4'h1, 124'h0});
        host_write(1, {4'h8, 124'h0});
        inst_ready = 1'b1;
        arm(0);
        @(negedge clk);
        chk("t1_busy", DATA_W'(busy), DATA_W'(1));
        chk("t1_v0", DATA_W'(inst_valid), DATA_W'(0));
        @(negedge clk);
        chk("t1_v1", DATA_W'(inst_valid), DATA_W'(0));
        @(negedge clk);
        chk("t1_v2", DATA_W'(inst_valid), DATA_W'(1));
        chk("t1_pc0", DATA_W'(inst_pc), DATA_W'(0));
        @(negedge clk);
        chk("t1_pc1", DATA_W'(inst_pc), DATA_W'(1));
        chk("t1_done", DATA_W'(done), DATA_W'(1));
        @(negedge clk);
        chk("t1_busy_fall", DATA_W'(busy), DATA_W'(0));
        tick();

        // Back-pressure: FIFO fills to 4, reads stop, then full rate.
        for (int i = 0; i < 8; i++) host_write(i, {4'h2, 124'(i * 7 + 3)});
        host_write(8, {4'h8, 124'h55});
        inst_ready = 1'b0;
        arm(0);
        repeat (10) @(negedge clk);
        chk("t2_count", DATA_W'(dut.fifo_count), DATA_W'(4));
        chk("t2_addr", DATA_W'(sram_addr), DATA_W'(3));
        tick();
        junk       = {4'hF, 124'h0BAD};
        host_we    = 1'b1;
        host_addr  = ADDR_W'(5);
        host_wdata = junk;
        @(negedge clk);
        chk("t2_ack_busy", DATA_W'(host_ack), DATA_W'(0));
        chk("t2_we_busy", DATA_W'(sram_we), DATA_W'(0));
        tick();
        host_we = 1'b0;
        @(negedge clk);
        chk("t2_addr_hold", DATA_W'(sram_addr), DATA_W'(3));
        chk("t2_word5", sram[5], ref_mem[5]);
        tick();
        inst_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("t2_b2b", DATA_W'(inst_valid), DATA_W'(1));
        end
        wait_idle("t2", 20);
        chk("t2_len", DATA_W'(got_pc.size()), DATA_W'(9));
        for (int i = 0; i < 9 && i < got_pc.size(); i++)
            chk("t2_order", DATA_W'(got_pc[i]), DATA_W'(i));
        tick();

        // host_we has priority over start in IDLE.
        junk       = {4'h5, 124'h1234};
        host_we    = 1'b1;
        host_addr  = ADDR_W'(20);
        host_wdata = junk;
        ref_mem[20] = junk;
        start      = 1'b1;
        start_pc   = '0;
        @(negedge clk);
        chk("t4_ack", DATA_W'(host_ack), DATA_W'(1));
        chk("t4_we", DATA_W'(sram_we), DATA_W'(1));
        chk("t4_addr", DATA_W'(sram_addr), DATA_W'(20));
        tick();
        host_we    = 1'b0;
        start      = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        @(negedge clk);
        chk("t4_busy", DATA_W'(busy), DATA_W'(0));
        chk("t4_word", sram[20], junk);
        tick();

        // Abort with three entries buffered, then restart at 4.
        inst_ready = 1'b0;
        arm(0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("t5_first_valid", DATA_W'(inst_valid), DATA_W'(1));
        tick();
        tick();
        abort = 1'b1;
        exp_pc.delete();
        @(negedge clk);
        chk("t5_count", DATA_W'(dut.fifo_count), DATA_W'(3));
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("t5_busy", DATA_W'(busy), DATA_W'(0));
        chk("t5_valid", DATA_W'(inst_valid), DATA_W'(0));
        chk("t5_done", DATA_W'(done), DATA_W'(0));
        tick();
        inst_ready = 1'b1;
        arm(4);
        wait_idle("t5", 30);
        chk("t5_len", DATA_W'(got_pc.size()), DATA_W'(5));
        if (got_pc.size() > 0)
            chk("t5_first_pc", DATA_W'(got_pc[0]), DATA_W'(4));
        tick();

        // Asynchronous reset mid-run, then rerun.
        arm(0);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("t6_busy", DATA_W'(busy), DATA_W'(0));
        chk("t6_valid", DATA_W'(inst_valid), DATA_W'(0));
        chk("t6_done", DATA_W'(done), DATA_W'(0));
        chk("t6_we", DATA_W'(sram_we), DATA_W'(0));
        chk("t6_addr", DATA_W'(sram_addr), DATA_W'(0));
        chk("t6_d", sram_d, DATA_W'(0));
        exp_pc.delete();
        tick();
        rst_n = 1'b1;
        tick();
        arm(0);
        wait_idle("t6", 40);
        chk("t6_len", DATA_W'(got_pc.size()), DATA_W'(9));
        tick();

        // Wrap from 511 to 0; address 1 must never be delivered.
        host_write(510, {4'h3, 124'hA});
        host_write(511, {4'h3, 124'hB});
        host_write(0, {4'h8, 124'hC});
        host_write(1, {4'h4, 124'hD});
        arm(510);
        wait_idle("t3", 30);
        chk("t3_len", DATA_W'(got_pc.size()), DATA_W'(3));
        if (got_pc.size() == 3) begin
            chk("t3_pc0", DATA_W'(got_pc[0]), DATA_W'(510));
            chk("t3_pc1", DATA_W'(got_pc[1]), DATA_W'(511));
            chk("t3_pc2", DATA_W'(got_pc[2]), DATA_W'(0));
        end
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
Sequencer for the NPU instruction SRAM (128-bit x 512 words, 1-cycle synchronous read, write-enable port).
- While idle, it gives a host loader write access to the SRAM.
- On start, it fetches instructions from a start PC into a small prefetch FIFO. It presents them to the decoder over a valid/ready handshake until a HALT instruction is delivered.
- It sits between the host/config path, the instruction SRAM and the NPU decoder.

Parameters:
ADDR_W, 9, SRAM address width / PC width
DATA_W, 128, instruction width
FIFO_DEPTH, 4, prefetch FIFO entries (power of 2, >=4 for 1 instr/cycle)
HALT_OP, 4'h8, opcode value in inst[127:124] that ends a program

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin fetching at start_pc (sampled in IDLE only)
start_pc  in  ADDR_W  first instruction address
abort  in  1  terminate the run; return to IDLE
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse when the HALT instruction is accepted
host_we  in  1  host write request
host_addr  in  ADDR_W  host write address
host_wdata  in  DATA_W  host write data
host_ack  out  1  host write accepted this cycle
sram_addr  out  ADDR_W  to SRAM address
sram_d  out  DATA_W  to SRAM write data
sram_we  out  1  to SRAM write enable
sram_q  in  DATA_W  SRAM read data, valid the cycle after the address is presented
inst_valid  out  1  inst_data/inst_pc valid
inst_ready  in  1  decoder accepts when valid&ready
inst_data  out  DATA_W  FIFO head instruction
inst_pc  out  ADDR_W  address of inst_data

Behaviour:
- Reset: state=IDLE; pc=0; FIFO empty; rd_pend=0; halt_seen=0. Outputs: busy=0, done=0, inst_valid=0, host_ack=0, sram_we=0, sram_addr=0, sram_d=0.
- States: IDLE, FETCH, DRAIN.
- IDLE, host access:
  - host_ack = host_we (combinational).
  - sram_we=host_we, sram_addr=host_addr, sram_d=host_wdata.
  - host_we has priority over start: if both are high in the same cycle, the write happens and start is ignored.
- IDLE, start: start && !host_we at edge E0 -> pc<=start_pc, state<=FETCH.
- Outside IDLE, host writes: host_we is ignored, host_ack=0 and sram_we=0.
- FETCH, read issue:
  - A read is issued in cycle C iff !halt_seen && (fifo_count + rd_pend) < FIFO_DEPTH.
  - On issue: sram_addr=pc and pc<=pc+1, wrapping 511->0.
  - rd_pend<=issue; the pc tag travels with rd_pend.
  - fifo_count excludes any pop in the same cycle.
  - When no read is issued, sram_addr holds its last value.
- FETCH, data return:
  - If rd_pend and !halt_seen, sram_q and its pc tag are pushed at the end of the cycle.
  - If sram_q[127:124]==HALT_OP: halt_seen<=1 and state<=DRAIN. Any read issued in that same cycle returns next cycle and is discarded (not pushed).
- Latency: start sampled at E0 -> read issued in cycle E0+1 -> sram_q in E0+2 -> inst_valid=1 from cycle E0+3.
- Throughput: with inst_ready held high, one instruction per cycle sustained.
- Decoder handshake:
  - inst_valid = !fifo_empty.
  - A pop happens on valid&ready.
  - inst_data and inst_pc are stable while valid && !ready.
  - Push and pop in the same cycle are both legal, including when the FIFO is full with a simultaneous pop. No push is ever attempted while full without a pop, by the credit rule.
- DRAIN:
  - No reads are issued.
  - When the HALT entry is popped: done=1 for that cycle; at that edge state<=IDLE, FIFO cleared, halt_seen<=0.
  - The HALT entry is always the last entry in the FIFO.
- abort (any non-IDLE state): at the next edge state<=IDLE, FIFO flushed, rd_pend<=0, halt_seen<=0, no done. Any pop in the abort cycle still completes.
- Reset asserted mid-run: immediate return to the reset values above. SRAM contents are untouched.
- No HALT in program: fetch wraps around the address space indefinitely until abort.

Decomposition:
- Package npu_inst_pkg:
  - ADDR_W, DATA_W.
  - Opcode field bounds (OP_HI=127, OP_LO=124).
  - HALT_OP.
  - Fetch state enum {IDLE, FETCH, DRAIN}.
- Sub-module inst_fifo: synchronous FIFO, width DATA_W+ADDR_W, depth FIFO_DEPTH.
  - Ports: push, pop, flush, count, empty, full.
  - Pointer-based, with count output.
  - Reused later for the data path.

Test Plan:
- Host loads mem[0]=128'h1000..., mem[1]=128'h8000...; then start, start_pc=0, inst_ready=1.
  -> inst_valid rises 3 cycles after start with inst_pc=0, then inst_pc=1 (HALT).
  -> done pulses in the HALT accept cycle; busy falls the next cycle.
- Load 8 non-HALT words at 0-7 and HALT at 8; start_pc=0; hold inst_ready=0 for 10 cycles.
  -> fifo_count=4 and no further reads are issued.
  -> On releasing ready, inst_pc 0..8 arrive back-to-back in order, with no gaps after refill.
- Wrap: non-HALT words at 510 and 511, HALT at 0; start_pc=510.
  -> inst_pc sequence is 510, 511, 0; done asserts; the word at address 1 is never delivered.
- host_we=1 together with start in IDLE -> write occurs, host_ack=1, busy stays 0.
  - host_we during FETCH -> host_ack=0, sram_we=0, and a later readback shows the target word unchanged.
- abort 2 cycles after first inst_valid, with 3 entries buffered -> next cycle busy=0, inst_valid=0, no done.
  - A new start then delivers from the new start_pc correctly.
- rst_n pulsed low mid-FETCH -> all outputs go to their reset values asynchronously; after release, start re-runs the program correctly.
